mem_delay_responder: RTL

Memory-side responder for the processor's single-outstanding-request memory bus. Accepts one-cycle read/write request pulses, holds the request for a fixed programmable latency while signalling busy, then returns a one-cycle ack with read data. Sits between the processor and the word-addressed backing store in simulation and FPGA builds. Provides an out-of-band write port so a bench or loader can preload the program.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/word_ram.sv | 28 ++
 rtl/mem_delay_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the delayed memory responder.
// Exports e_mem_state, default sizes, and an address range helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } e_mem_state;

  localparam int unsigned MEM_SIZE_WORDS_DEF = 4096;
  localparam int unsigned LATENCY_DEF = 4;

  function automatic logic in_range(
    input logic [29:0] w,
    input int unsigned n
  );
    return {2'b00, w} < n;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word array: request and OOB write ports, one registered read port.
// Ports: clk, req_we/addr/wdata, oob_we/addr/wdata, rd_en/addr, rd_data.
module word_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic          oob_we,
  input  logic [AW-1:0] oob_addr,
  input  logic [31:0]   oob_wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Request write is issued last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (oob_we) mem[oob_addr] <= oob_wdata;
    if (req_we) mem[req_addr] <= req_wdata;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_delay_responder.sv
// Single-outstanding memory responder with fixed request-to-ack latency.
// Ports: clk, rst, mem_* request/ack bus, addr_err, oob_* preload port.
module mem_delay_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = MEM_SIZE_WORDS_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack,
  output logic        mem_busy,
  output logic        addr_err,
  input  logic        oob_wen,
  input  logic [31:0] oob_wr_addr,
  input  logic [31:0] oob_wr_data
);

  localparam int unsigned AW =
    (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;

  e_mem_state  state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [29:0] idx;
  logic        is_wr;
  logic [31:0] wdata;
  logic        ok;
  logic [31:0] rd_hold;
  logic [31:0] ram_q;
  logic [31:0] rd_val;
  logic        req;
  logic        idle;
  logic        enter_ack;
  logic [29:0] cur_idx;
  logic        cur_wr;
  logic [31:0] cur_data;
  logic        cur_ok;
  logic        oob_ok;
  logic        unused_ok;

  assign unused_ok = ^{mem_addr[1:0], oob_wr_addr[1:0]};

  assign req  = mem_rd_req | mem_wr_req;
  assign idle = (state == IDLE);

  // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
  assign cur_idx  = idle ? mem_addr[31:2] : idx;
  assign cur_wr   = idle ? mem_wr_req : is_wr;
  assign cur_data = idle ? mem_wr_data : wdata;
  assign cur_ok   = in_range(cur_idx, MEM_SIZE_WORDS);
  assign oob_ok   = in_range(oob_wr_addr[31:2], MEM_SIZE_WORDS);

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = (LATENCY == 1) ? ACK : WAIT;
          cnt_n = 8'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 8'd1) begin
          state_n = ACK;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_ack = !rst && (state != ACK) && (state_n == ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      idx     <= '0;
      is_wr   <= 1'b0;
      wdata   <= '0;
      ok      <= 1'b0;
      rd_hold <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (idle && req) begin
        idx   <= mem_addr[31:2];
        is_wr <= mem_wr_req;
        wdata <= mem_wr_data;
        ok    <= cur_ok;
      end
      if (state == ACK && !is_wr) rd_hold <= rd_val;
    end
  end

  word_ram #(
    .DEPTH(MEM_SIZE_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk      (clk),
    .req_we   (enter_ack && cur_wr && cur_ok),
    .req_addr (cur_idx[AW-1:0]),
    .req_wdata(cur_data),
    .oob_we   (oob_wen && oob_ok),
    .oob_addr (oob_wr_addr[AW+1:2]),
    .oob_wdata(oob_wr_data),
    .rd_en    (enter_ack && !cur_wr && cur_ok),
    .rd_addr  (cur_idx[AW-1:0]),
    .rd_data  (ram_q)
  );

  assign rd_val = ok ? ram_q : 32'd0;

  assign mem_ack  = (state == ACK);
  assign mem_busy = !idle;
  assign addr_err = (state == ACK) && !ok;
  assign mem_rd_data = (state == ACK && !is_wr) ? rd_val : rd_hold;

endmodule
